// File: rtl/hammer_strike_ctrl.sv
// Hammer sprite sequencer: on every frame start it writes position and pose code
// to the sprite core, and steps RAISE -> STRIKE -> RETURN after a strike request.
module hammer_strike_ctrl #(
    parameter int         DWELL       = 4,
    parameter logic [4:0] CTRL_IDLE   = 5'b00100,
    parameter logic [4:0] CTRL_RAISE  = 5'b01000,
    parameter logic [4:0] CTRL_STRIKE = 5'b01100,
    parameter logic [4:0] CTRL_RETURN = 5'b01000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [10:0] tgt_x,
    input  logic [10:0] tgt_y,
    input  logic        strike,
    output logic        cs,
    output logic        write,
    output logic [13:0] addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        hit,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RAISE, S_STRIKE, S_RETURN} state_t;

    localparam logic [3:0] LAST = 4'(DWELL - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hit_nxt, done_nxt;
    logic        cond, cond_p1, sof_p1;
    logic [1:0]  bcnt;
    logic        pending;
    logic        sof_go, accept;
    logic [4:0]  ctrl_cur;
    logic [10:0] pos_x, pos_y, burst_y;
    logic [4:0]  burst_ctrl;

    assign cond   = (x == 11'd0) && (y == 11'd0);
    // A frame start that lands inside a burst is dropped entirely.
    assign sof_go = sof_p1 && (bcnt == 2'd0);
    assign accept = pending && (state == S_IDLE) && (bcnt == 2'd0) && !sof_p1;
    assign busy   = (state != S_IDLE) || pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hit   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hit   <= hit_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hit_nxt   = 1'b0;
        done_nxt  = 1'b0;
        ctrl_cur  = CTRL_IDLE;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_RAISE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                case (state)
                    S_RAISE:  ctrl_cur = CTRL_RAISE;
                    S_STRIKE: ctrl_cur = CTRL_STRIKE;
                    default:  ctrl_cur = CTRL_RETURN;
                endcase
                if (sof_go) begin
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        case (state)
                            S_RAISE: begin
                                state_nxt = S_STRIKE;
                                hit_nxt   = 1'b1;
                            end
                            S_STRIKE: state_nxt = S_RETURN;
                            default: begin
                                state_nxt = S_IDLE;
                                done_nxt  = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    // Stage p1: frame-start edge detect, strike request, write burst
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_p1 <= 1'b1;
            sof_p1  <= 1'b0;
            pending <= 1'b0;
            bcnt    <= 2'd0;
            cs      <= 1'b0;
            write   <= 1'b0;
            addr    <= 14'h0;
            wr_data <= 32'h0;
        end else begin
            cond_p1 <= cond;
            sof_p1  <= cond && !cond_p1;
            if (accept)
                pending <= 1'b0;
            else if (strike && !busy)
                pending <= 1'b1;
            case (bcnt)
                2'd0: begin
                    if (sof_go) begin
                        bcnt    <= 2'd1;
                        cs      <= 1'b1;
                        write   <= 1'b1;
                        addr    <= 14'h2001;
                        wr_data <= {21'd0, (state == S_IDLE) ? tgt_x : pos_x};
                    end else begin
                        cs      <= 1'b0;
                        write   <= 1'b0;
                        addr    <= 14'h0;
                        wr_data <= 32'h0;
                    end
                end
                2'd1: begin
                    bcnt    <= 2'd2;
                    addr    <= 14'h2002;
                    wr_data <= {21'd0, burst_y};
                end
                2'd2: begin
                    bcnt    <= 2'd3;
                    addr    <= 14'h2003;
                    wr_data <= {27'd0, burst_ctrl};
                end
                default: begin
                    bcnt    <= 2'd0;
                    cs      <= 1'b0;
                    write   <= 1'b0;
                    addr    <= 14'h0;
                    wr_data <= 32'h0;
                end
            endcase
        end
    end

    // Burst payload is frozen at frame start so all three writes agree.
    always_ff @(posedge clk) begin
        if (accept) begin
            pos_x <= tgt_x;
            pos_y <= tgt_y;
        end
        if (sof_go) begin
            burst_y    <= (state == S_IDLE) ? tgt_y : pos_y;
            burst_ctrl <= ctrl_cur;
        end
    end

endmodule
